// File: rtl/raster_addr_gen_pkg.sv
// Shared definitions for the raster address generator and the downstream
// pixel decoder: bpp encoding, command word field layout and bus widths.
package raster_addr_gen_pkg;

  localparam int ADDR_W = 20;
  localparam int CMD_W  = 32;

  typedef enum logic [2:0] {
    BPP_1  = 3'd0,
    BPP_2  = 3'd1,
    BPP_4  = 3'd2,
    BPP_8  = 3'd3,
    BPP_16 = 3'd4
  } bpp_mode_e;

  // Command word field offsets and widths
  localparam int CMD_BITOFS   = 0;
  localparam int CMD_BITOFS_W = 4;
  localparam int CMD_BPP      = 4;
  localparam int CMD_BPP_W    = 3;
  localparam int CMD_VALID    = 7;
  localparam int CMD_LAYER    = 8;
  localparam int CMD_LAYER_W  = 3;
  localparam int CMD_HCNT     = 11;
  localparam int CMD_HCNT_W   = 4;

  // Codes 5..7 are unused encodings and fold onto 16 bpp.
  function automatic logic [2:0] eff_bpp(input logic [2:0] mode);
    return (mode > 3'(BPP_16)) ? 3'(BPP_16) : mode;
  endfunction

  // Index of the last pixel in a 16-bit word: 16>>mode minus one.
  function automatic logic [3:0] pix_last(input logic [2:0] mode);
    return 4'd15 >> mode;
  endfunction

endpackage

// File: rtl/raster_addr_gen_if.sv
// Bus bundle between the video timing/config side and one raster address
// generator; the master drives timing and config, the slave returns the
// RAM address and pass-thru command word.
interface raster_addr_gen_if;
  import raster_addr_gen_pkg::*;

  logic [3:0]        pc_ena_in;
  logic              h_ena;
  logic              new_line;
  logic              new_frame;
  logic              enable;
  logic [ADDR_W-1:0] base_addr;
  logic [15:0]       pitch;
  logic [3:0]        h_scale;
  logic [3:0]        v_scale;
  logic [2:0]        bpp_mode;
  logic [ADDR_W-1:0] addr_out;
  logic [CMD_W-1:0]  cmd_out;

  modport master (
    output pc_ena_in, h_ena, new_line, new_frame, enable,
           base_addr, pitch, h_scale, v_scale, bpp_mode,
    input  addr_out, cmd_out
  );

  modport slave (
    input  pc_ena_in, h_ena, new_line, new_frame, enable,
           base_addr, pitch, h_scale, v_scale, bpp_mode,
    output addr_out, cmd_out
  );

endinterface

// File: rtl/raster_scale_counter.sv
// Generic repeat counter: counts advance strobes up to a limit and then
// returns to zero. WRAP_ON_GE selects whether a count already past the
// limit (after the limit was lowered) wraps at once or runs on to overflow.
module raster_scale_counter #(
  parameter int CNT_W      = 4,
  parameter bit WRAP_ON_GE = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_tick,
  input  logic             i_clear,
  input  logic             i_adv,
  input  logic [CNT_W-1:0] i_limit,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_at_limit;

  assign w_at_limit = WRAP_ON_GE ? (r_cnt >= i_limit) : (r_cnt == i_limit);
  assign o_cnt      = r_cnt;

  // Clear wins over advance; nothing moves off the update tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_tick) begin
      if (i_clear) begin
        r_cnt <= '0;
      end else if (i_adv) begin
        r_cnt <= w_at_limit ? '0 : CNT_W'(r_cnt + 1'b1);
      end
    end
  end

endmodule

// File: rtl/raster_addr_gen.sv
// Per-layer read-address generator. Each update tick produces the byte
// address and command word of the pixel being displayed, then advances the
// internal pointer to the next pixel (with horizontal/vertical repeat).
module raster_addr_gen
  import raster_addr_gen_pkg::*;
#(
  parameter logic [3:0] PC_UPDATE_PHASE = 4'd4,
  parameter logic [2:0] LAYER_ID        = 3'd0
) (
  input  logic             clk,
  input  logic             reset,
  raster_addr_gen_if.slave bus
);

  logic [ADDR_W-1:0] r_line_base;
  logic [ADDR_W-1:0] r_ptr;
  logic [3:0]        r_pix_idx;
  logic [ADDR_W-1:0] r_addr_out;
  logic [CMD_W-1:0]  r_cmd_out;

  logic              w_tick;
  logic              w_do_frame;
  logic              w_do_line;
  logic              w_do_pix;
  logic [3:0]        w_h_cnt;
  logic [3:0]        w_v_cnt;
  logic              w_h_wrap;
  logic              w_v_wrap;
  logic [2:0]        w_bpp;
  logic              w_pix_wrap;
  logic [ADDR_W-1:0] w_base_even;
  logic [ADDR_W-1:0] w_pitch_even;

  logic [ADDR_W-1:0] w_line_base_nx;
  logic [ADDR_W-1:0] w_ptr_nx;
  logic [3:0]        w_pix_idx_nx;
  logic [ADDR_W-1:0] w_addr_out_nx;
  logic [CMD_W-1:0]  w_cmd_out_nx;

  assign w_tick     = (bus.pc_ena_in == PC_UPDATE_PHASE);
  assign w_do_frame = bus.new_frame;
  assign w_do_line  = !bus.new_frame && bus.new_line;
  assign w_do_pix   = !bus.new_frame && !bus.new_line && bus.h_ena;

  raster_scale_counter #(.CNT_W(4), .WRAP_ON_GE(1'b1)) u_h_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_tick  (w_tick),
    .i_clear (bus.new_frame | bus.new_line),
    .i_adv   (w_do_pix),
    .i_limit (bus.h_scale),
    .o_cnt   (w_h_cnt)
  );

  raster_scale_counter #(.CNT_W(4), .WRAP_ON_GE(1'b0)) u_v_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_tick  (w_tick),
    .i_clear (bus.new_frame),
    .i_adv   (w_do_line),
    .i_limit (bus.v_scale),
    .o_cnt   (w_v_cnt)
  );

  // Same limit tests the counters use internally to decide their wrap.
  assign w_h_wrap = (w_h_cnt >= bus.h_scale);
  assign w_v_wrap = (w_v_cnt == bus.v_scale);

  assign w_bpp        = eff_bpp(bus.bpp_mode);
  // ">=" also catches a pixel index left out of range by a bpp change.
  assign w_pix_wrap   = (r_pix_idx >= pix_last(w_bpp));
  assign w_base_even  = bus.base_addr & ~ADDR_W'(1);
  assign w_pitch_even = {4'b0000, bus.pitch & 16'hFFFE};

  // Next pointer/line state and the outputs to register on this tick.
  always_comb begin
    w_line_base_nx = r_line_base;
    w_ptr_nx       = r_ptr;
    w_pix_idx_nx   = r_pix_idx;
    w_addr_out_nx  = r_ptr;
    w_cmd_out_nx   = '0;

    if (w_do_frame) begin
      w_line_base_nx = w_base_even;
      w_ptr_nx       = w_base_even;
      w_pix_idx_nx   = 4'd0;
      w_addr_out_nx  = w_base_even;
    end else if (w_do_line) begin
      if (w_v_wrap) begin
        w_line_base_nx = r_line_base + w_pitch_even;
      end
      w_ptr_nx      = w_line_base_nx;
      w_pix_idx_nx  = 4'd0;
      w_addr_out_nx = w_line_base_nx;
    end else if (w_do_pix) begin
      if (w_h_wrap) begin
        if (w_pix_wrap) begin
          w_pix_idx_nx = 4'd0;
          w_ptr_nx     = r_ptr + ADDR_W'(2);
        end else begin
          w_pix_idx_nx = r_pix_idx + 4'd1;
        end
      end
    end

    // Strobe ticks report the fresh line start; others the current pixel.
    if (!(bus.new_frame || bus.new_line)) begin
      w_cmd_out_nx[CMD_BITOFS +: CMD_BITOFS_W] = 4'(r_pix_idx << w_bpp);
      w_cmd_out_nx[CMD_HCNT +: CMD_HCNT_W]     = w_h_cnt;
    end
    w_cmd_out_nx[CMD_BPP +: CMD_BPP_W]     = w_bpp;
    w_cmd_out_nx[CMD_VALID]                = bus.enable & bus.h_ena;
    w_cmd_out_nx[CMD_LAYER +: CMD_LAYER_W] = LAYER_ID;
  end

  // State and outputs move together, only on the update phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_line_base <= '0;
      r_ptr       <= '0;
      r_pix_idx   <= '0;
      r_addr_out  <= '0;
      r_cmd_out   <= '0;
    end else if (w_tick) begin
      r_line_base <= w_line_base_nx;
      r_ptr       <= w_ptr_nx;
      r_pix_idx   <= w_pix_idx_nx;
      r_addr_out  <= w_addr_out_nx;
      r_cmd_out   <= w_cmd_out_nx;
    end
  end

  assign bus.addr_out = r_addr_out;
  assign bus.cmd_out  = r_cmd_out;

endmodule

// File: tb/tb_raster_addr_gen.sv
// Directed bench for raster_addr_gen: frame/line/pixel sequencing, scaling,
// bpp packing, address wrap, layer enable and phase gating.
module tb_raster_addr_gen;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  raster_addr_gen_if bus ();

  raster_addr_gen #(
    .PC_UPDATE_PHASE (4'd4),
    .LAYER_ID        (3'd5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: got no end expected end of run");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One full pixel period (phases 0..4); strobes held for the whole period.
  task automatic pixel(input logic nf, input logic nl, input logic he);
    for (int p = 0; p < 5; p++) begin
      @(negedge clk);
      bus.pc_ena_in = 4'(p);
      bus.new_frame = nf;
      bus.new_line  = nl;
      bus.h_ena     = he;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic config_layer(input logic [19:0] base, input logic [15:0] pit,
                              input logic [3:0] hs, input logic [3:0] vs,
                              input logic [2:0] bpp, input logic en);
    bus.base_addr = base;
    bus.pitch     = pit;
    bus.h_scale   = hs;
    bus.v_scale   = vs;
    bus.bpp_mode  = bpp;
    bus.enable    = en;
  endtask

  logic [19:0] exp_a1 [5];
  logic [3:0]  exp_o1 [5];
  logic [19:0] exp_l3 [4];

  initial begin
    n_cmp = 0;
    n_err = 0;
    exp_a1 = '{20'h01234, 20'h01234, 20'h01236, 20'h01236, 20'h01238};
    exp_o1 = '{4'd0, 4'd8, 4'd0, 4'd8, 4'd0};
    exp_l3 = '{20'h00000, 20'h00000, 20'h00140, 20'h00140};

    reset = 1'b1;
    bus.pc_ena_in = 4'd0;
    bus.h_ena = 1'b0;
    bus.new_line = 1'b0;
    bus.new_frame = 1'b0;
    config_layer(20'h0, 16'h0, 4'd0, 4'd0, 3'd0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("reset_addr", 32'(bus.addr_out), 32'h0);
    check("reset_cmd", bus.cmd_out, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // 8 bpp, no scaling
    config_layer(20'h01234, 16'h0, 4'd0, 4'd0, 3'd3, 1'b1);
    pixel(1'b1, 1'b0, 1'b0);
    check("t1_frame_addr", 32'(bus.addr_out), 32'h01234);
    check("t1_frame_cmd", bus.cmd_out, 32'h00000530);
    for (int k = 0; k < 5; k++) begin
      pixel(1'b0, 1'b0, 1'b1);
      check($sformatf("t1_addr%0d", k), 32'(bus.addr_out), 32'(exp_a1[k]));
      check($sformatf("t1_ofs%0d", k), 32'(bus.cmd_out[3:0]), 32'(exp_o1[k]));
      if (k == 0) check("t1_cmd_first", bus.cmd_out, 32'h000005B0);
    end

    // 1 bpp, each pixel repeated twice
    config_layer(20'h00000, 16'h0, 4'd1, 4'd0, 3'd0, 1'b1);
    pixel(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 33; k++) begin
      pixel(1'b0, 1'b0, 1'b1);
      check($sformatf("t2_addr%0d", k), 32'(bus.addr_out), (k < 32) ? 32'h0 : 32'h2);
      check($sformatf("t2_ofs%0d", k), 32'(bus.cmd_out[3:0]), (k < 32) ? 32'(k / 2) : 32'h0);
      check($sformatf("t2_hcnt%0d", k), 32'(bus.cmd_out[14:11]), 32'(k % 2));
    end

    // Line pitch with vertical repeat of 3
    config_layer(20'h00000, 16'h0140, 4'd0, 4'd2, 3'd3, 1'b1);
    pixel(1'b1, 1'b0, 1'b0);
    check("t3_line0", 32'(bus.addr_out), 32'h0);
    for (int k = 0; k < 4; k++) begin
      pixel(1'b0, 1'b1, 1'b0);
      check($sformatf("t3_line%0d", k + 1), 32'(bus.addr_out), 32'(exp_l3[k]));
    end

    // Simultaneous new_frame/new_line; odd pitch bit ignored
    config_layer(20'h004F0, 16'h0141, 4'd0, 4'd1, 3'd4, 1'b1);
    pixel(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) pixel(1'b0, 1'b0, 1'b1);
    pixel(1'b0, 1'b0, 1'b0);
    check("t4_advanced", 32'(bus.addr_out), 32'h00500);
    bus.base_addr = 20'h00100;
    pixel(1'b1, 1'b1, 1'b0);
    check("t4_both", 32'(bus.addr_out), 32'h00100);
    check("t4_both_ofs", 32'(bus.cmd_out[3:0]), 32'h0);
    pixel(1'b0, 1'b1, 1'b0);
    check("t4_line_rep", 32'(bus.addr_out), 32'h00100);
    pixel(1'b0, 1'b1, 1'b0);
    check("t4_line_next", 32'(bus.addr_out), 32'h00240);

    // Top-of-memory wrap; unused bpp code folds to 16 bpp; odd base masked
    config_layer(20'hFFFFF, 16'h0, 4'd0, 4'd0, 3'd7, 1'b1);
    pixel(1'b1, 1'b0, 1'b0);
    check("t5_frame", 32'(bus.addr_out), 32'hFFFFE);
    check("t5_bpp_fold", 32'(bus.cmd_out[6:4]), 32'h4);
    pixel(1'b0, 1'b0, 1'b1);
    check("t5_addr0", 32'(bus.addr_out), 32'hFFFFE);
    pixel(1'b0, 1'b0, 1'b1);
    check("t5_addr1", 32'(bus.addr_out), 32'h00000);

    // Disabled layer keeps tracking; off-phase h_ena is ignored
    config_layer(20'h00000, 16'h0, 4'd0, 4'd0, 3'd4, 1'b0);
    pixel(1'b1, 1'b0, 1'b0);
    pixel(1'b0, 1'b0, 1'b1);
    check("t6_dis_addr0", 32'(bus.addr_out), 32'h0);
    check("t6_dis_valid0", 32'(bus.cmd_out[7]), 32'h0);
    pixel(1'b0, 1'b0, 1'b1);
    check("t6_dis_addr1", 32'(bus.addr_out), 32'h2);
    check("t6_dis_valid1", 32'(bus.cmd_out[7]), 32'h0);
    for (int p = 0; p < 5; p++) begin
      @(negedge clk);
      bus.pc_ena_in = 4'(p);
      bus.h_ena     = (p != 4);
    end
    @(posedge clk);
    #1;
    check("t6_offphase", 32'(bus.addr_out), 32'h4);
    bus.enable = 1'b1;
    pixel(1'b0, 1'b0, 1'b1);
    check("t6_en_addr", 32'(bus.addr_out), 32'h4);
    check("t6_en_valid", 32'(bus.cmd_out[7]), 32'h1);

    // Asynchronous reset mid-line, away from any clock edge
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("async_rst_addr", 32'(bus.addr_out), 32'h0);
    check("async_rst_cmd", bus.cmd_out, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
